// File: rtl/digit_pkg.sv
// digit_pkg: frame constants and FSM state type shared by the frame loader, pixel
// buffer and inference core. ST_CHECK exists only when FRAME_CHECKSUM_EN is defined.
package digit_pkg;

  localparam int         N_PIXELS_DEFAULT  = 784;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
  localparam int         PIX_ADDR_W        = 10;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LOAD,
`ifdef FRAME_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_START,
    ST_WAIT_INFER
  } state_t;

endpackage

// File: rtl/byte_timeout.sv
// byte_timeout: loadable down-counter with enable and clear that emits a single-cycle
// expire pulse TIMEOUT_CLKS-1 cycles after the last clear (TIMEOUT_CLKS must be >= 3).
module byte_timeout #(
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS);
  // Two short of the limit: one cycle goes to the reload, one to registering the pulse.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CLKS - 2);

  logic [CNT_W-1:0] r_count;
  logic             r_expire;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= LOAD_VAL;
      r_expire <= 1'b0;
    end else if (i_clear) begin
      r_count  <= LOAD_VAL;
      r_expire <= 1'b0;
    end else if (i_en) begin
      r_expire <= (r_count == CNT_W'(1));
      if (r_count != '0) r_count <= r_count - CNT_W'(1);
    end else begin
      r_expire <= 1'b0;
    end
  end

  assign o_expire = r_expire;

endmodule

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: hunts for the sync byte, writes N_PIXELS bytes to the pixel buffer,
// then starts inference. Define FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_frame_loader
  import digit_pkg::*;
#(
  parameter int         N_PIXELS     = N_PIXELS_DEFAULT,
  parameter int         ADDR_W       = PIX_ADDR_W,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 2_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_infer_done,
  output logic              o_pix_we,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [7:0]        o_pix_data,
  output logic              o_infer_start,
  output logic              o_busy,
  output logic              o_frame_ok,
  output logic              o_err_timeout,
  output logic              o_err_checksum,
  output logic              o_err_overrun
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIXELS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic              r_pix_we;
  logic [ADDR_W-1:0] r_pix_addr;
  logic [7:0]        r_pix_data;
  logic              r_infer_start;
  logic              r_busy;
  logic              r_frame_ok;
  logic              r_err_timeout;
  logic              r_err_overrun;
  logic              w_timer_en;
  logic              w_expire;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic              r_err_checksum;

  assign w_timer_en = (r_state == ST_LOAD) || (r_state == ST_CHECK);
`else
  assign w_timer_en = (r_state == ST_LOAD);
`endif

  byte_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_byte_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_timer_en),
    .i_clear (i_rx_valid),
    .o_expire(w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_HUNT;
      r_pix_cnt     <= '0;
      r_pix_we      <= 1'b0;
      r_pix_addr    <= '0;
      r_pix_data    <= '0;
      r_infer_start <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_csum         <= '0;
      r_err_checksum <= 1'b0;
`endif
    end else begin
      r_pix_we      <= 1'b0;
      r_infer_start <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_err_checksum <= 1'b0;
`endif
      case (r_state)
        ST_HUNT: begin
          if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
            r_state   <= ST_LOAD;
            r_busy    <= 1'b1;
            r_pix_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_csum    <= '0;
`endif
          end
        end
        // A byte arriving in the expiry cycle wins over the timeout.
        ST_LOAD: begin
          if (i_rx_valid) begin
            r_pix_we   <= 1'b1;
            r_pix_addr <= r_pix_cnt;
            r_pix_data <= i_rx_data;
`ifdef FRAME_CHECKSUM_EN
            r_csum     <= r_csum ^ i_rx_data;
`endif
            if (r_pix_cnt == LAST_PIX) begin
`ifdef FRAME_CHECKSUM_EN
              r_state <= ST_CHECK;
`else
              r_state <= ST_START;
`endif
            end else begin
              r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
          end else if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_HUNT;
          end
        end
`ifdef FRAME_CHECKSUM_EN
        // A matching checksum fires the start strobes directly so they land one cycle after the byte.
        ST_CHECK: begin
          if (i_rx_valid) begin
            if (i_rx_data == r_csum) begin
              r_infer_start <= 1'b1;
              r_frame_ok    <= 1'b1;
              r_state       <= ST_WAIT_INFER;
            end else begin
              r_err_checksum <= 1'b1;
              r_busy         <= 1'b0;
              r_state        <= ST_HUNT;
            end
          end else if (w_expire) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_HUNT;
          end
        end
`endif
        ST_START: begin
          r_infer_start <= 1'b1;
          r_frame_ok    <= 1'b1;
          r_state       <= ST_WAIT_INFER;
        end
        ST_WAIT_INFER: begin
          if (i_rx_valid) r_err_overrun <= 1'b1;
          if (i_infer_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_HUNT;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_HUNT;
        end
      endcase
    end
  end

  assign o_pix_we      = r_pix_we;
  assign o_pix_addr    = r_pix_addr;
  assign o_pix_data    = r_pix_data;
  assign o_infer_start = r_infer_start;
  assign o_busy        = r_busy;
  assign o_frame_ok    = r_frame_ok;
  assign o_err_timeout = r_err_timeout;
  assign o_err_overrun = r_err_overrun;
`ifdef FRAME_CHECKSUM_EN
  assign o_err_checksum = r_err_checksum;
`else
  assign o_err_checksum = 1'b0;
`endif

endmodule
